// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions, trap cause code and trap-FSM states
// for the machine-mode CSR / timer-trap unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIP_MTIP_BIT     = 7;

  localparam logic [31:0] MCAUSE_MTI    = 32'h8000_0007;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN     = 1'b0,
    IN_TRAP = 1'b1
  } trap_state_e;

  // Places a single flag bit at its architectural position in a 32-bit CSR word.
  function automatic logic [31:0] bit_at(input logic v, input int unsigned pos);
    bit_at = 32'(v) << pos;
  endfunction

endpackage

// File: rtl/csr_trap_unit_cycle_counter64.sv
// 64-bit free-running cycle counter with independently loadable halves;
// a load in a cycle replaces that cycle's increment.
module cycle_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_lo_i,
  input  logic        load_hi_i,
  input  logic        inc_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_lo_i || load_hi_i) begin
      if (load_lo_i) count_d[31:0]  = wdata_i;
      if (load_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with timer-interrupt trap entry and MRET return.
// Trap/MRET decisions are combinational; architectural updates land on the next edge.
//
// state   | meaning
// RUN     | normal execution, no trap handler active
// IN_TRAP | timer trap taken, waiting for MRET
module csr_trap_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_intr,
  input  logic        instr_valid,
  input  logic [31:0] pc_in,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        is_mret,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic [31:0] trap_pc,
  output logic        mret_taken,
  output logic [31:0] epc_out
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        pending_q, pending_d;
  trap_state_e state_q;

  logic        trap_fire;
  logic        mret_fire;
  logic        wr_en;
  logic [63:0] mcycle;

  assign trap_fire = reset & pending_q & mie_mtie_q & mstatus_mie_q & instr_valid;
  assign mret_fire = reset & is_mret & instr_valid & ~trap_fire;
  // A trap flushes the instruction, so its CSR write is dropped too.
  assign wr_en     = csr_wr & ~trap_fire;

  assign trap_taken = trap_fire;
  assign trap_pc    = mtvec_q;
  assign mret_taken = mret_fire;
  assign epc_out    = mepc_q;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    pending_d      = timer_intr | (pending_q & ~trap_fire);

    if (trap_fire) begin
      mepc_d         = pc_in & ALIGN4_MASK;
      mcause_d       = MCAUSE_MTI;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else begin
      if (wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    mie_mtie_d = csr_wdata[MIE_MTIE_BIT];
          CSR_MTVEC:  mtvec_d    = csr_wdata & ALIGN4_MASK;
          CSR_MEPC:   mepc_d     = csr_wdata & ALIGN4_MASK;
          CSR_MCAUSE: mcause_d   = csr_wdata;
          default: ;
        endcase
      end
      // MRET's stack pop wins over a same-cycle software write to mstatus.
      if (mret_fire) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      pending_q      <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      pending_q      <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (trap_fire) state_q <= IN_TRAP;
        IN_TRAP: if (mret_fire) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  cycle_counter64 u_mcycle (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_lo_i (wr_en && (csr_addr == CSR_MCYCLE)),
    .load_hi_i (wr_en && (csr_addr == CSR_MCYCLEH)),
    .inc_i     (1'b1),
    .wdata_i   (csr_wdata),
    .count_o   (mcycle)
  );

  always_comb begin
    csr_rdata = '0;
    if (csr_rd) begin
      case (csr_addr)
        CSR_MSTATUS: csr_rdata = bit_at(mstatus_mie_q, MSTATUS_MIE_BIT)
                               | bit_at(mstatus_mpie_q, MSTATUS_MPIE_BIT);
        CSR_MIE:     csr_rdata = bit_at(mie_mtie_q, MIE_MTIE_BIT);
        CSR_MTVEC:   csr_rdata = mtvec_q;
        CSR_MEPC:    csr_rdata = mepc_q;
        CSR_MCAUSE:  csr_rdata = mcause_q;
        CSR_MIP:     csr_rdata = bit_at(pending_q, MIP_MTIP_BIT);
        CSR_MCYCLE:  csr_rdata = mcycle[31:0];
        CSR_MCYCLEH: csr_rdata = mcycle[63:32];
        default:     csr_rdata = '0;
      endcase
    end
  end

  a_trap_enters_handler: assert property (@(posedge clk) disable iff (!reset)
    trap_fire |=> (state_q == IN_TRAP));
  a_redirects_exclusive: assert property (@(posedge clk)
    !(trap_taken && mret_taken));

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_csr_trap_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        timer_intr, instr_valid, csr_rd, csr_wr, is_mret;
  logic [31:0] pc_in, csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, trap_pc, epc_out;
  logic        trap_taken, mret_taken;

  csr_trap_unit dut (
    .clk(clk), .reset(reset), .timer_intr(timer_intr), .instr_valid(instr_valid),
    .pc_in(pc_in), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .is_mret(is_mret), .csr_rdata(csr_rdata),
    .trap_taken(trap_taken), .trap_pc(trap_pc), .mret_taken(mret_taken),
    .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  localparam int S_RDATA = 0, S_TRAP = 1, S_TPC = 2, S_MRET = 3, S_EPC = 4;

  typedef struct {
    int          tag;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        S_RDATA: act = csr_rdata;
        S_TRAP:  act = {31'd0, trap_taken};
        S_TPC:   act = trap_pc;
        S_MRET:  act = {31'd0, mret_taken};
        default: act = epc_out;
      endcase
      checks = checks + 1;
      if (e.tag != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)", e.name, e.tag, cyc);
      end else if (act !== e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
    if (trap_taken === 1'b1 || mret_taken === 1'b1) begin
      checks = checks + 1;
      if (trap_taken && mret_taken) begin
        errors = errors + 1;
        $display("FAIL exclusive_redirect: trap_taken=%b mret_taken=%b, expected not both", trap_taken, mret_taken);
      end
    end
    if (done && sb.size() > 0) begin
      errors = errors + 1;
      $display("FAIL leftover: %0d expectations never checked", sb.size());
      sb.delete();
    end
  end

  task automatic push(input int sel, input logic [31:0] v, input string name);
    exp_t e;
    e.tag = cyc; e.sel = sel; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle();
    timer_intr = 0; instr_valid = 0; pc_in = '0; csr_rd = 0; csr_wr = 0;
    csr_addr = '0; csr_wdata = '0; is_mret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle(); csr_wr = 1; csr_addr = a; csr_wdata = d;
    tick();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] v, input string name);
    idle(); csr_rd = 1; csr_addr = a;
    push(S_RDATA, v, name);
    tick();
  endtask

  task automatic pulse_timer();
    idle(); timer_intr = 1;
    push(S_TRAP, 32'd0, "no_trap_on_pulse");
    tick();
  endtask

  task automatic do_mret(input logic [31:0] epc, input string name);
    idle(); instr_valid = 1; is_mret = 1; pc_in = 32'h0000_0999;
    push(S_MRET, 32'd1, {name, "_mret"});
    push(S_EPC, epc, {name, "_epc"});
    push(S_TRAP, 32'd0, {name, "_notrap"});
    tick();
  endtask

  initial begin
    idle();
    reset = 0;
    tick(); tick();
    // Reset held with every trigger asserted: no redirect may escape.
    idle(); instr_valid = 1; is_mret = 1; timer_intr = 1;
    push(S_TRAP, 32'd0, "reset_trap");
    push(S_MRET, 32'd0, "reset_mret");
    tick();
    reset = 1;
    rd(CSR_MSTATUS, 32'h0, "rst_mstatus");
    rd(CSR_MIE,     32'h0, "rst_mie");
    rd(CSR_MTVEC,   32'h0, "rst_mtvec");
    rd(CSR_MEPC,    32'h0, "rst_mepc");
    rd(CSR_MCAUSE,  32'h0, "rst_mcause");
    rd(CSR_MIP,     32'h0, "rst_mip");

    wr(CSR_MTVEC, 32'h0000_0103);
    rd(CSR_MTVEC, 32'h0000_0100, "mtvec_align");
    wr(CSR_MIE, 32'hFFFF_FFFF);
    rd(CSR_MIE, 32'h0000_0080, "mie_mask");
    wr(CSR_MSTATUS, 32'h0000_0008);
    rd(CSR_MSTATUS, 32'h0000_0008, "mstatus_wr");
    wr(CSR_MIP, 32'hFFFF_FFFF);
    wr(12'h123, 32'hDEAD_BEEF);
    rd(12'h123, 32'h0, "unimpl_read");
    rd(CSR_MIP, 32'h0, "mip_readonly");

    pulse_timer();
    idle(); instr_valid = 1; pc_in = 32'h40; csr_rd = 1; csr_addr = CSR_MSTATUS;
    push(S_RDATA, 32'h8, "trap1_rdata_pre");
    push(S_TRAP, 32'd1, "trap1_taken");
    push(S_TPC, 32'h100, "trap1_pc");
    push(S_MRET, 32'd0, "trap1_nomret");
    tick();
    rd(CSR_MEPC,    32'h40, "trap1_mepc");
    rd(CSR_MCAUSE,  32'h8000_0007, "trap1_mcause");
    rd(CSR_MSTATUS, 32'h80, "trap1_mstatus");
    rd(CSR_MIP,     32'h0, "trap1_mip");
    do_mret(32'h40, "ret1");
    rd(CSR_MSTATUS, 32'h88, "ret1_mstatus");

    wr(CSR_MSTATUS, 32'h0);
    idle(); timer_intr = 1; instr_valid = 1; pc_in = 32'h44;
    push(S_TRAP, 32'd0, "dis_pulse_notrap");
    tick();
    idle(); instr_valid = 1; pc_in = 32'h48; csr_rd = 1; csr_addr = CSR_MIP;
    push(S_RDATA, 32'h80, "dis_mip_pending");
    push(S_TRAP, 32'd0, "dis_notrap");
    tick();
    idle(); csr_wr = 1; csr_rd = 1; csr_addr = CSR_MSTATUS; csr_wdata = 32'h8;
    push(S_RDATA, 32'h0, "wr_cycle_prevalue");
    tick();
    idle(); instr_valid = 1; pc_in = 32'h80;
    push(S_TRAP, 32'd1, "enable_trap");
    push(S_TPC, 32'h100, "enable_trap_pc");
    tick();
    rd(CSR_MIP,     32'h0, "enable_mip_clear");
    rd(CSR_MEPC,    32'h80, "enable_mepc");
    rd(CSR_MSTATUS, 32'h80, "enable_mstatus");
    do_mret(32'h80, "ret2");

    pulse_timer();
    idle(); instr_valid = 1; pc_in = 32'h200; csr_wr = 1; csr_addr = CSR_MIE;
    csr_wdata = 32'h0; is_mret = 1; timer_intr = 1;
    push(S_TRAP, 32'd1, "prio_trap");
    push(S_MRET, 32'd0, "prio_nomret");
    push(S_EPC, 32'h80, "prio_epc_old");
    tick();
    rd(CSR_MIE,     32'h80, "prio_mie_kept");
    rd(CSR_MEPC,    32'h200, "prio_mepc");
    rd(CSR_MIP,     32'h80, "coincident_pending");
    rd(CSR_MSTATUS, 32'h80, "prio_mstatus");
    do_mret(32'h200, "ret3");
    idle(); instr_valid = 1; pc_in = 32'h300;
    push(S_TRAP, 32'd1, "late_enable_trap");
    push(S_TPC, 32'h100, "late_enable_pc");
    tick();
    rd(CSR_MEPC, 32'h300, "late_mepc");
    do_mret(32'h300, "ret4");

    wr(CSR_MCYCLE,  32'hFFFF_FFFF);
    wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
    rd(CSR_MCYCLEH, 32'hFFFF_FFFF, "mcycleh_loaded");
    rd(CSR_MCYCLE,  32'h0, "mcycle_wrap_lo");
    rd(CSR_MCYCLEH, 32'h0, "mcycle_wrap_hi");
    rd(CSR_MCYCLE,  32'h2, "mcycle_count");

    pulse_timer();
    idle(); reset = 0; instr_valid = 1; pc_in = 32'h400;
    push(S_TRAP, 32'd0, "rst_mid_trap");
    push(S_MRET, 32'd0, "rst_mid_mret");
    tick();
    reset = 1;
    rd(CSR_MSTATUS, 32'h0, "rst2_mstatus");
    rd(CSR_MIE,     32'h0, "rst2_mie");
    rd(CSR_MTVEC,   32'h0, "rst2_mtvec");
    rd(CSR_MEPC,    32'h0, "rst2_mepc");
    rd(CSR_MCAUSE,  32'h0, "rst2_mcause");
    rd(CSR_MIP,     32'h0, "rst2_mip");
    rd(CSR_MCYCLEH, 32'h0, "rst2_mcycleh");
    idle(); instr_valid = 1; pc_in = 32'h500;
    push(S_TRAP, 32'd0, "rst2_notrap");
    tick();

    idle();
    done = 1'b1;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
